ex_cond_unit: RTL and testbench

Execute-stage condition unit for the pipelined ARM core. It captures the decoder's condition-sensitive control bits into the ID/EX boundary and holds the architectural NZCV flag register. It evaluates the instruction's condition field against the stored flags and gates register write, memory write and branch. A taken branch squashes the instruction behind it.

---
 rtl/ex_cond_unit.sv | 106 ++++++++++
 tb/tb_ex_cond_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_cond_unit.sv
// Execute-stage condition unit: ID/EX control register, NZCV flag register, condition gating.
// Optional statistics counters are built when COND_STATS_EN is defined.
module ex_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondD,
    input  logic [1:0]       FlagWD,
    input  logic             PCSD,
    input  logic             RegWD,
    input  logic             MemWD,
    input  logic [3:0]       ALUFlagsE,
    output logic             CondExE,
    output logic             PCSrcE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic [3:0]       FlagsE
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
`endif
);

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
    } idex_t;

    idex_t      ex;
    logic [3:0] flags;
    logic       cond_pass;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_pass = 1'b0;
        unique case (ex.cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            4'b1111: cond_pass = 1'b0;
        endcase
    end

    // Gating uses only registered state, so ALUFlagsE never reaches these outputs.
    assign CondExE   = ex.valid & cond_pass;
    assign PCSrcE    = ex.pcs  & CondExE;
    assign RegWriteE = ex.regw & CondExE;
    assign MemWriteE = ex.memw & CondExE;
    assign FlagsE    = flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex    <= '0;
            flags <= '0;
        end else begin
            // A taken branch squashes the wrong-path instruction even while stalled.
            if (FlushE | PCSrcE) begin
                ex <= '0;
            end else if (!StallE) begin
                ex.valid <= 1'b1;
                ex.cond  <= CondD;
                ex.flagw <= FlagWD;
                ex.pcs   <= PCSD;
                ex.regw  <= RegWD;
                ex.memw  <= MemWD;
            end
            if (CondExE & ex.flagw[1]) flags[3:2] <= ALUFlagsE[3:2];
            if (CondExE & ex.flagw[0]) flags[1:0] <= ALUFlagsE[1:0];
        end
    end

`ifdef COND_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ExecCnt   <= '0;
            SquashCnt <= '0;
        end else if (!StallE && ex.valid) begin
            if (CondExE) ExecCnt   <= ExecCnt + 1'b1;
            else         SquashCnt <= SquashCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_cond_unit.sv
// Self-checking bench for ex_cond_unit: directed vector table, hand sequences, and
// randomized stimulus against an architectural model of condition execution.
module tb_ex_cond_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             StallE, FlushE;
    logic [3:0]       CondD;
    logic [1:0]       FlagWD;
    logic             PCSD, RegWD, MemWD;
    logic [3:0]       ALUFlagsE;
    logic             CondExE, PCSrcE, RegWriteE, MemWriteE;
    logic [3:0]       FlagsE;
    logic [CNT_W-1:0] ExecCnt, SquashCnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    ex_cond_unit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallE    (StallE),
        .FlushE    (FlushE),
        .CondD     (CondD),
        .FlagWD    (FlagWD),
        .PCSD      (PCSD),
        .RegWD     (RegWD),
        .MemWD     (MemWD),
        .ALUFlagsE (ALUFlagsE),
        .CondExE   (CondExE),
        .PCSrcE    (PCSrcE),
        .RegWriteE (RegWriteE),
        .MemWriteE (MemWriteE),
        .FlagsE    (FlagsE)
`ifdef COND_STATS_EN
        ,
        .ExecCnt   (ExecCnt),
        .SquashCnt (SquashCnt)
`endif
    );

`ifndef COND_STATS_EN
    assign ExecCnt   = '0;
    assign SquashCnt = '0;
`endif

    // ---------------- architectural model ----------------
    typedef struct {
        bit       valid;
        bit [3:0] cond;
        bit [1:0] fw;
        bit       pcs, rw, mw;
    } slot_t;

    slot_t            m_ex;
    bit               m_n, m_z, m_c, m_v;
    logic [CNT_W-1:0] m_exec, m_sq;

    // Base predicate selected by cond[3:1]; odd encodings are the negation.
    function automatic bit cond_holds(input bit [3:0] cc, input bit n, z, c, v);
        bit r;
        case (cc[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        return cc[0] ? !r : r;
    endfunction

    function automatic bit m_cx();
        return m_ex.valid && cond_holds(m_ex.cond, m_n, m_z, m_c, m_v);
    endfunction

    task automatic model_reset();
        m_ex = '{default: 0};
        {m_n, m_z, m_c, m_v} = 4'b0000;
        m_exec = '0;
        m_sq   = '0;
    endtask

    task automatic model_step(input bit st, fl, input bit [3:0] cc, input bit [1:0] fw,
                              input bit pcs, rw, mw, input bit [3:0] alu);
        bit cx, taken;
        cx    = m_cx();
        taken = cx && m_ex.pcs;
        if (cx && m_ex.fw[1]) {m_n, m_z} = alu[3:2];
        if (cx && m_ex.fw[0]) {m_c, m_v} = alu[1:0];
        if (!st && m_ex.valid) begin
            if (cx) m_exec = m_exec + 1'b1;
            else    m_sq   = m_sq + 1'b1;
        end
        if (fl || taken)  m_ex = '{default: 0};
        else if (!st)     m_ex = '{1'b1, cc, fw, pcs, rw, mw};
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit st, fl, input bit [3:0] cc, input bit [1:0] fw,
                         input bit pcs, rw, mw, input bit [3:0] alu);
        StallE = st; FlushE = fl; CondD = cc; FlagWD = fw;
        PCSD = pcs; RegWD = rw; MemWD = mw; ALUFlagsE = alu;
        model_step(st, fl, cc, fw, pcs, rw, mw, alu);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_check(input string tag);
        bit cx;
        cx = m_cx();
        check({tag, ".CondExE"},   {31'd0, CondExE},   {31'd0, cx});
        check({tag, ".PCSrcE"},    {31'd0, PCSrcE},    {31'd0, cx && m_ex.pcs});
        check({tag, ".RegWriteE"}, {31'd0, RegWriteE}, {31'd0, cx && m_ex.rw});
        check({tag, ".MemWriteE"}, {31'd0, MemWriteE}, {31'd0, cx && m_ex.mw});
        check({tag, ".FlagsE"},    {28'd0, FlagsE},    {28'd0, m_n, m_z, m_c, m_v});
`ifdef COND_STATS_EN
        check({tag, ".ExecCnt"},   32'(ExecCnt),       32'(m_exec));
        check({tag, ".SquashCnt"}, 32'(SquashCnt),     32'(m_sq));
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".CondExE"},   {31'd0, CondExE},   32'd0);
        check({tag, ".PCSrcE"},    {31'd0, PCSrcE},    32'd0);
        check({tag, ".RegWriteE"}, {31'd0, RegWriteE}, 32'd0);
        check({tag, ".MemWriteE"}, {31'd0, MemWriteE}, 32'd0);
        check({tag, ".FlagsE"},    {28'd0, FlagsE},    32'd0);
`ifdef COND_STATS_EN
        check({tag, ".ExecCnt"},   32'(ExecCnt),       32'd0);
        check({tag, ".SquashCnt"}, 32'(SquashCnt),     32'd0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #10;
        reset = 1'b1;
    endtask

    task automatic branch_seq(input bit st, input string tag);
        drive(1'b0, 1'b0, 4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        check({tag, ".taken"},    {31'd0, PCSrcE},    32'd1);
        drive(st, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        check({tag, ".pcs_once"}, {31'd0, PCSrcE},    32'd0);
        check({tag, ".bubble"},   {31'd0, CondExE},   32'd0);
        check({tag, ".squashed"}, {31'd0, RegWriteE}, 32'd0);
        drive(1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        check({tag, ".resume"},   {31'd0, RegWriteE}, 32'd1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit       st, fl;
        bit [3:0] cc;
        bit [1:0] fw;
        bit       pcs, rw, mw;
        bit [3:0] alu;
        bit       x_cx, x_pc, x_rw, x_mw;
        bit [3:0] x_fl;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b0;
        StallE = 1'b0; FlushE = 1'b0; CondD = 4'h0; FlagWD = 2'b00;
        PCSD = 1'b0; RegWD = 1'b0; MemWD = 1'b0; ALUFlagsE = 4'h0;
        model_reset();
        @(posedge clk); #1;
        check_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b1;

        //                st    fl    cond     fw     pcs   rw    mw    alu        cx    pc    rw    mw    flags
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 4'b0000,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1111,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0100,  1'b1, 1'b0, 1'b1, 1'b0, 4'b0100});
        vecs.push_back('{1'b0, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1111,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0100});
        vecs.push_back('{1'b0, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0100,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0100});
        vecs.push_back('{1'b0, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0100});
        vecs.push_back('{1'b0, 1'b0, 4'b1010, 2'b00, 1'b0, 1'b1, 1'b0, 4'b1000,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1000});
        vecs.push_back('{1'b0, 1'b0, 4'b1011, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1000});
        vecs.push_back('{1'b0, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000,  1'b1, 1'b0, 1'b0, 1'b0, 4'b1000});
        vecs.push_back('{1'b0, 1'b0, 4'b1100, 2'b00, 1'b0, 1'b1, 1'b0, 4'b1001,  1'b1, 1'b0, 1'b1, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 2'b00, 1'b1, 1'b1, 1'b1, 4'b0000,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 1'b0, 4'b1101, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back('{1'b1, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 1'b1, 4'b1110, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 1'b0, 4'b1000, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 1'b0, 4'b1001, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000,  1'b1, 1'b0, 1'b0, 1'b1, 4'b1001});
        vecs.push_back('{1'b0, 1'b0, 4'b0110, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000,  1'b1, 1'b0, 1'b1, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 1'b0, 4'b0100, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0000,  1'b1, 1'b0, 1'b1, 1'b1, 4'b1001});
        vecs.push_back('{1'b0, 1'b0, 4'b0011, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000,  1'b1, 1'b0, 1'b1, 1'b0, 4'b1001});
        vecs.push_back('{1'b0, 1'b0, 4'b1110, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000,  1'b1, 1'b0, 1'b0, 1'b0, 4'b1001});
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0010,  1'b1, 1'b0, 1'b0, 1'b0, 4'b1010});
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0011,  1'b1, 1'b0, 1'b0, 1'b0, 4'b1011});
        vecs.push_back('{1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0001,  1'b1, 1'b0, 1'b0, 1'b0, 4'b1001});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].fl, vecs[i].cc, vecs[i].fw,
                  vecs[i].pcs, vecs[i].rw, vecs[i].mw, vecs[i].alu);
            tick();
            check($sformatf("vec%0d.CondExE", i),   {31'd0, CondExE},   {31'd0, vecs[i].x_cx});
            check($sformatf("vec%0d.PCSrcE", i),    {31'd0, PCSrcE},    {31'd0, vecs[i].x_pc});
            check($sformatf("vec%0d.RegWriteE", i), {31'd0, RegWriteE}, {31'd0, vecs[i].x_rw});
            check($sformatf("vec%0d.MemWriteE", i), {31'd0, MemWriteE}, {31'd0, vecs[i].x_mw});
            check($sformatf("vec%0d.FlagsE", i),    {28'd0, FlagsE},    {28'd0, vecs[i].x_fl});
        end

        // ---------------- branch squash, plain and with stall ----------------
        branch_seq(1'b0, "branch");
        branch_seq(1'b1, "branch_stall");

        // ---------------- asynchronous reset mid-stream ----------------
        drive(1'b0, 1'b0, 4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        drive(1'b0, 1'b0, 4'b1110, 2'b00, 1'b1, 1'b1, 1'b1, 4'b1111);
        tick();
        check("pre_reset.PCSrcE", {31'd0, PCSrcE}, 32'd1);
        check("pre_reset.FlagsE", {28'd0, FlagsE}, 32'hF);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_zero("async_reset");
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        check("post_reset.RegWriteE", {31'd0, RegWriteE}, 32'd1);

        // ---------------- randomized against the model ----------------
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(3) == 0, $urandom_range(7) == 0, 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            tick();
            model_check($sformatf("rnd%0d", i));
        end

`ifdef COND_STATS_EN
        // ---------------- counter wrap and stall behaviour ----------------
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
            tick();
        end
        check("stats.exec15",   32'(ExecCnt),   32'd15);
        check("stats.stall_sq", 32'(SquashCnt), 32'd1);
        drive(1'b0, 1'b1, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        check("stats.squash2",  32'(SquashCnt), 32'd2);
        drive(1'b0, 1'b0, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        check("stats.bubble",   32'(ExecCnt),   32'd15);
        drive(1'b0, 1'b1, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        check("stats.wrap",     32'(ExecCnt),   32'd0);
        check("stats.sq_keep",  32'(SquashCnt), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
